// File: rtl/mul_div_if.sv
// Request/write-back bundle between the core and the iterative RV32M multiply/divide unit.
interface mul_div_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic            kill;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd_addr_in;
    logic            busy;
    logic            rf_wr_en;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] wr_data;

    modport master (
        output start, kill, op, rs1_data, rs2_data, rd_addr_in,
        input  busy, rf_wr_en, rd_addr, wr_data
    );

    modport slave (
        input  start, kill, op, rs1_data, rs2_data, rd_addr_in,
        output busy, rf_wr_en, rd_addr, wr_data
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply, restoring divide, one op at a time.
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero, signed overflow and zero-operand multiply skip CALC.
module mul_div_unit #(
    parameter int unsigned XLEN = 32
) (
    input logic     clk,
    input logic     res_n,
    mul_div_if.slave bus
);
    localparam int unsigned CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [2:0]        op_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   d_q;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;
    logic              neg_q;
    logic              neg_r;

    logic              is_div_c, a_signed_c, b_signed_c, a_neg_c, b_neg_c, b_zero_c;
    logic [XLEN-1:0]   a_mag_c, b_mag_c;
    logic [XLEN:0]     mul_sum_c, div_sh_c, div_diff_c;
    logic [2*XLEN-1:0] prod_c, prod_fix_c;
    logic [XLEN-1:0]   q_fix_c, r_fix_c, result_c;

    // Operand decode: signedness per funct3, magnitudes for the unsigned core
    always_comb begin
        is_div_c   = bus.op[2];
        a_signed_c = (bus.op == 3'd0) || (bus.op == 3'd1) || (bus.op == 3'd2) ||
                     (bus.op == 3'd4) || (bus.op == 3'd6);
        b_signed_c = (bus.op == 3'd0) || (bus.op == 3'd1) ||
                     (bus.op == 3'd4) || (bus.op == 3'd6);
        a_neg_c    = a_signed_c && bus.rs1_data[XLEN-1];
        b_neg_c    = b_signed_c && bus.rs2_data[XLEN-1];
        a_mag_c    = a_neg_c ? -bus.rs1_data : bus.rs1_data;
        b_mag_c    = b_neg_c ? -bus.rs2_data : bus.rs2_data;
        b_zero_c   = (bus.rs2_data == '0);
    end

    // One iteration step and the final sign fix / result select
    always_comb begin
        mul_sum_c  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, d_q} : '0);
        div_sh_c   = {hi_q, lo_q[XLEN-1]};
        div_diff_c = div_sh_c - {1'b0, d_q};
        prod_c     = {hi_q, lo_q};
        prod_fix_c = neg_q ? -prod_c : prod_c;
        q_fix_c    = neg_q ? -lo_q : lo_q;
        r_fix_c    = neg_r ? -hi_q : hi_q;
        case (op_q)
            3'd0:          result_c = prod_fix_c[XLEN-1:0];
            3'd1, 3'd2, 3'd3: result_c = prod_fix_c[2*XLEN-1:XLEN];
            3'd4, 3'd5:    result_c = q_fix_c;
            default:       result_c = r_fix_c;
        endcase
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic            ovf_c, early_c;
    logic [XLEN-1:0] early_hi_c, early_lo_c;

    // Results that are known without iterating, laid out so FIX produces them unchanged
    always_comb begin
        ovf_c      = is_div_c && a_signed_c &&
                     (bus.rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.rs2_data);
        early_c    = is_div_c ? (b_zero_c || ovf_c) : ((bus.rs1_data == '0) || b_zero_c);
        early_hi_c = (is_div_c && b_zero_c) ? a_mag_c : '0;
        early_lo_c = is_div_c ? (b_zero_c ? '1 : a_mag_c) : '0;
    end
`endif

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state        <= IDLE;
            cnt          <= '0;
            op_q         <= '0;
            rd_q         <= '0;
            d_q          <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            bus.busy     <= 1'b0;
            bus.rf_wr_en <= 1'b0;
            bus.rd_addr  <= '0;
            bus.wr_data  <= '0;
        end else begin
            bus.rf_wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.kill) begin
                        op_q     <= bus.op;
                        rd_q     <= bus.rd_addr_in;
                        d_q      <= is_div_c ? b_mag_c : a_mag_c;
                        lo_q     <= is_div_c ? a_mag_c : b_mag_c;
                        hi_q     <= '0;
                        // Divide by zero keeps the all-ones quotient unsigned; remainder sign restores A
                        neg_q    <= is_div_c ? (!b_zero_c && (a_neg_c ^ b_neg_c)) : (a_neg_c ^ b_neg_c);
                        neg_r    <= is_div_c && a_neg_c;
                        cnt      <= CW'(XLEN);
                        bus.busy <= 1'b1;
                        state    <= CALC;
`ifdef MULDIV_EARLY_OUT_EN
                        if (early_c) begin
                            hi_q  <= early_hi_c;
                            lo_q  <= early_lo_c;
                            state <= FIX;
                        end
`endif
                    end
                end
                CALC: begin
                    if (bus.kill) begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        if (op_q[2]) begin
                            hi_q <= div_diff_c[XLEN] ? div_sh_c[XLEN-1:0] : div_diff_c[XLEN-1:0];
                            lo_q <= {lo_q[XLEN-2:0], !div_diff_c[XLEN]};
                        end else begin
                            hi_q <= mul_sum_c[XLEN:1];
                            lo_q <= {mul_sum_c[0], lo_q[XLEN-1:1]};
                        end
                        cnt <= cnt - CW'(1);
                        if (cnt == CW'(1)) state <= FIX;
                    end
                end
                FIX: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                    if (!bus.kill) begin
                        bus.wr_data  <= result_c;
                        bus.rd_addr  <= rd_q;
                        bus.rf_wr_en <= 1'b1;
                    end
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule
